// File: rtl/move_request_arbiter.sv
// Sequences player moves into the 2048 core: debounced buttons and keyboard strobes
// are merged into a small FIFO and issued one at a time behind an idle/busy/idle handshake.
module move_request_arbiter #(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             btn_dir,
  input  logic                   kbd_valid,
  input  logic [3:0]             kbd_dir,
  input  logic                   core_ready,
  input  logic [1:0]             game_state,
  output logic [3:0]             direction_out,
  output logic                   dir_valid,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   dropped
);
  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CNTW = PW + 1;
  localparam int unsigned DW   = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY} state_e;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  state_e          state_q, state_d;
  logic            low_seen_q, low_seen_d;
  logic            armed_q, armed_d;
  logic [DW-1:0]   cnt_q, cnt_d, cnt_next;
  logic [3:0]      btn_last_q, btn_last_d;
  logic [3:0]      mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [3:0]      dir_q, dir_d;
  logic            valid_q, valid_d;
  logic            dropped_q, dropped_d;
  logic            playing, btn_req, kbd_req, push_req, push_ok, pop_en, full;
  logic [3:0]      push_data;

  assign playing = (game_state == 2'b01);

  // Button debounce: arm on release, count stable one-hot cycles, fire once, then disarm.
  always_comb begin
    armed_d    = armed_q;
    cnt_d      = '0;
    cnt_next   = '0;
    btn_req    = 1'b0;
    btn_last_d = btn_dir;
    if (btn_dir == 4'b0000) begin
      armed_d = 1'b1;
    end else if (armed_q && is_onehot(btn_dir)) begin
      cnt_next = (btn_dir == btn_last_q) ? cnt_q + DW'(1) : DW'(1);
      if (cnt_next == DW'(DEBOUNCE)) begin
        btn_req = 1'b1;
        armed_d = 1'b0;
      end else begin
        cnt_d = cnt_next;
      end
    end
  end

  // Request FIFO with fixed button priority; a pop frees room for a same-cycle push.
  always_comb begin
    kbd_req   = kbd_valid && is_onehot(kbd_dir);
    push_req  = btn_req || kbd_req;
    push_data = btn_req ? btn_dir : kbd_dir;
    pop_en    = playing && (state_q == S_ISSUE);
    full      = (count_q == CNTW'(DEPTH));
    push_ok   = playing && push_req && (!full || pop_en);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    dropped_d = 1'b0;
    if (!playing) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d   = count_q + CNTW'(push_ok) - CNTW'(pop_en);
      dropped_d = (btn_req && kbd_req) || (push_req && full && !pop_en);
    end
  end

  // Issue sequencing; outputs are computed with the next state so they are registered.
  always_comb begin
    state_d    = state_q;
    low_seen_d = low_seen_q;
    dir_d      = '0;
    valid_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((count_q != '0) && core_ready && playing) begin
          state_d = S_ISSUE;
          dir_d   = mem_q[rd_ptr_q];
          valid_d = 1'b1;
        end
      end
      S_ISSUE: begin
        state_d    = S_WAIT_BUSY;
        low_seen_d = 1'b0;
      end
      S_WAIT_BUSY: begin
        if (!low_seen_q) begin
          if (!core_ready) low_seen_d = 1'b1;
        end else if (core_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!playing) begin
      state_d    = S_IDLE;
      low_seen_d = 1'b0;
      dir_d      = '0;
      valid_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      low_seen_q <= 1'b0;
      armed_q    <= 1'b0;
      cnt_q      <= '0;
      btn_last_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      dir_q      <= '0;
      valid_q    <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      low_seen_q <= low_seen_d;
      armed_q    <= armed_d;
      cnt_q      <= cnt_d;
      btn_last_q <= btn_last_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      dir_q      <= dir_d;
      valid_q    <= valid_d;
      dropped_q  <= dropped_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !rst) mem_q[wr_ptr_q] <= push_data;
  end

  assign direction_out = dir_q;
  assign dir_valid     = valid_q;
  assign fifo_count    = count_q;
  assign dropped       = dropped_q;
endmodule
